// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS32 control FSM: sequences fetch/decode/execute over a shared memory
// and ALU, with a memory-stall timeout, illegal-opcode trap and retired-instruction counter.
module mips_multicycle_control #(
    parameter int CNT_W      = 32,
    parameter int WAIT_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Opcode,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             IRWrite,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount,
    output logic             Trap,
    output logic [1:0]       TrapCause
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // The counter holds stalls already taken; the trap fires on the stall that makes WAIT_LIMIT.
    localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] LAST_STALL = (WAIT_LIMIT > 0) ? WAIT_W'(WAIT_LIMIT - 1) : '0;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic [1:0]        cause_nxt;
    logic              mem_state;
    logic              timeout;
    logic              retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RESET;
            wait_cnt   <= '0;
            TrapCause  <= CAUSE_NONE;
            InstrCount <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            TrapCause <= cause_nxt;
            if (retire) begin
                InstrCount <= InstrCount + CNT_W'(1);
            end
        end
    end

    assign State     = state;
    assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout   = (WAIT_LIMIT != 0) && mem_state && !MemReady && (wait_cnt == LAST_STALL);

    always_comb begin
        state_nxt   = state;
        cause_nxt   = TrapCause;
        retire      = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        Trap        = 1'b0;

        case (state)
            S_RESET: state_nxt = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (MemReady) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    default: begin
                        state_nxt = S_TRAP;
                        cause_nxt = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                state_nxt = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                MemToReg  = 1'b1;
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) begin
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_EXEC: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_nxt   = S_FETCH;
                retire      = 1'b1;
            end
            S_JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                state_nxt = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_TRAP: Trap = 1'b1;
            default: begin
                state_nxt = S_TRAP;
                cause_nxt = CAUSE_ILLEGAL;
            end
        endcase

        if (timeout) begin
            state_nxt = S_TRAP;
            cause_nxt = CAUSE_TIMEOUT;
        end
    end

    // Stall counter restarts whenever a memory-access state is freshly entered.
    always_comb begin
        wait_nxt = wait_cnt;
        if (mem_state && !MemReady) begin
            wait_nxt = wait_cnt + WAIT_W'(1);
        end
        if ((state_nxt != state) &&
            ((state_nxt == S_FETCH) || (state_nxt == S_MEMRD) || (state_nxt == S_MEMWR))) begin
            wait_nxt = '0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed sequences with literal expectations plus a
// randomized run checked every cycle against an instruction-path reference model.
module tb_mips_multicycle_control;

    localparam int CNT_W      = 32;
    localparam int WAIT_LIMIT = 16;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       Opcode;
    logic             MemReady;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite;
    logic [1:0]       PCSource, ALUOp, ALUSrcB;
    logic             ALUSrcA, RegWrite, RegDst, Trap;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;
    logic [1:0]       TrapCause;
    logic [16:0]      dut_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    mips_multicycle_control #(.CNT_W(CNT_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .IRWrite(IRWrite), .PCSource(PCSource),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .State(State), .InstrCount(InstrCount), .Trap(Trap),
        .TrapCause(TrapCause)
    );

    always #5 clk = ~clk;

    assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite,
                       PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, Trap};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string name, input int s);
        chk(name, 64'(State), 64'(s));
    endtask

    // Reference model: current state code, remaining path of the instruction, stall run length.
    int               m_state;
    int               m_stall;
    logic [CNT_W-1:0] m_cnt;
    logic [1:0]       m_cause;
    int               path[$];

    task automatic m_reset();
        m_state = 0;
        m_stall = 0;
        m_cnt   = '0;
        m_cause = 2'b00;
        path.delete();
    endtask

    function automatic logic [16:0] exp_ctrl(input int s, input logic rdy);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, tr;
        logic [1:0] pcs, aop, asb;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, tr} = '0;
        pcs = 2'b00;
        aop = 2'b00;
        asb = 2'b00;
        case (s)
            1:  begin mrd = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
            2:  asb = 2'b11;
            3:  begin asa = 1'b1; asb = 2'b10; end
            4:  begin mrd = 1'b1; iord = 1'b1; end
            5:  begin m2r = 1'b1; rw = 1'b1; end
            6:  begin mwr = 1'b1; iord = 1'b1; end
            7:  begin asa = 1'b1; aop = 2'b10; end
            8:  begin rd = 1'b1; rw = 1'b1; end
            9:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            10: begin pcw = 1'b1; pcs = 2'b10; end
            11: begin asa = 1'b1; asb = 2'b10; end
            12: rw = 1'b1;
            13: tr = 1'b1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, asa, asb, rw, rd, tr};
    endfunction

    task automatic m_advance(input logic rdy, input logic [5:0] op);
        if (m_state == 0) begin
            m_state = 1;
            m_stall = 0;
        end else if (m_state == 13) begin
            m_state = 13;
        end else if (m_state == 2) begin
            path.delete();
            case (op)
                OP_LW:    begin path.push_back(3); path.push_back(4); path.push_back(5); end
                OP_SW:    begin path.push_back(3); path.push_back(6); end
                OP_RTYPE: begin path.push_back(7); path.push_back(8); end
                OP_BEQ:   path.push_back(9);
                OP_J:     path.push_back(10);
                OP_ADDI:  begin path.push_back(11); path.push_back(12); end
                default:  ;
            endcase
            if (path.size() == 0) begin
                m_state = 13;
                m_cause = 2'b01;
            end else begin
                m_state = path.pop_front();
            end
        end else if ((m_state == 1 || m_state == 4 || m_state == 6) && !rdy) begin
            m_stall++;
            if (WAIT_LIMIT != 0 && m_stall == WAIT_LIMIT) begin
                m_state = 13;
                m_cause = 2'b10;
            end
        end else begin
            if (m_state == 1) begin
                m_state = 2;
            end else if (path.size() == 0) begin
                m_state = 1;
                m_cnt   = m_cnt + CNT_W'(1);
            end else begin
                m_state = path.pop_front();
            end
            m_stall = 0;
        end
    endtask

    // Compare process: outputs are checked mid-cycle, then the model steps with the same inputs.
    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                m_reset();
                chk("rst_state", 64'(State), 64'd0);
                chk("rst_ctrl", 64'(dut_ctrl), 64'd0);
                chk("rst_count", 64'(InstrCount), 64'd0);
                chk("rst_cause", 64'(TrapCause), 64'd0);
            end else begin
                chk("state", 64'(State), 64'(m_state));
                chk("ctrl", 64'(dut_ctrl), 64'(exp_ctrl(m_state, MemReady)));
                chk("count", 64'(InstrCount), 64'(m_cnt));
                chk("cause", 64'(TrapCause), 64'(m_cause));
                chk("rd_wr_excl", 64'(MemRead & MemWrite), 64'd0);
                chk("regw_memw_excl", 64'(RegWrite & MemWrite), 64'd0);
                m_advance(MemReady, Opcode);
            end
        end
    end

    task automatic step(input logic [5:0] op, input logic rdy);
        @(posedge clk);
        #1;
        Opcode   = op;
        MemReady = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    // Runs one instruction starting in FETCH with MemReady high; reports cycles to the next FETCH.
    task automatic run_instr(input logic [5:0] op, input int exp_len, input string name,
                             output logic [16:0] last_ctrl, output int mw_cycles);
        int               n;
        logic             done;
        logic [CNT_W-1:0] c0;
        n         = 1;
        done      = 1'b0;
        mw_cycles = 0;
        last_ctrl = '0;
        c0        = InstrCount;
        Opcode    = op;
        MemReady  = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            step(op, 1'b1);
            if (State == 4'd1) begin
                done = 1'b1;
            end else begin
                n++;
                last_ctrl = dut_ctrl;
                if (MemWrite) mw_cycles++;
            end
        end
        chk({name, "_latency"}, 64'(n), 64'(exp_len));
        chk({name, "_retired"}, 64'(InstrCount), 64'(c0 + CNT_W'(1)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] lc;
        int          mw;
        int          trap_cycles;
        int          burst;
        int          r;
        logic [5:0]  legal [6];
        legal = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI};
        trap_cycles = 0;
        burst       = 0;

        rst      = 1'b1;
        Opcode   = OP_RTYPE;
        MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset_state", 0);
        chk("reset_ctrl", 64'(dut_ctrl), 64'd0);
        chk("reset_count", 64'(InstrCount), 64'd0);
        chk("reset_cause", 64'(TrapCause), 64'd0);
        rst = 1'b0;

        // R-type walk: 0 -> 1, 2, 7, 8, 1
        step(OP_RTYPE, 1'b1); chk_state("r_fetch", 1); chk("r_irwrite", 64'(IRWrite), 64'd1);
        step(OP_RTYPE, 1'b1); chk_state("r_decode", 2);
        step(OP_RTYPE, 1'b1); chk_state("r_exec", 7);
        step(OP_RTYPE, 1'b1); chk_state("r_aluwb", 8);
        chk("r_regwrite", 64'(RegWrite), 64'd1);
        chk("r_regdst", 64'(RegDst), 64'd1);
        step(OP_RTYPE, 1'b1); chk_state("r_back_fetch", 1);
        chk("r_count", 64'(InstrCount), 64'd1);

        run_instr(OP_LW, 5, "lw", lc, mw);
        chk("lw_memwb_ctrl", 64'(lc), 64'(17'b00000100000000100));
        chk("lw_no_write", 64'(mw), 64'd0);
        run_instr(OP_SW, 4, "sw", lc, mw);
        chk("sw_memwr_ctrl", 64'(lc), 64'(17'b00101000000000000));
        chk("sw_write_cycles", 64'(mw), 64'd1);
        run_instr(OP_BEQ, 3, "beq", lc, mw);
        chk("beq_ctrl", 64'(lc), 64'(17'b01000000101100000));
        run_instr(OP_J, 3, "j", lc, mw);
        chk("j_ctrl", 64'(lc), 64'(17'b10000001000000000));
        run_instr(OP_ADDI, 4, "addi", lc, mw);
        chk("addi_wb_ctrl", 64'(lc), 64'(17'b00000000000000100));
        chk("count_after_six", 64'(InstrCount), 64'd6);

        // Three stalled FETCH cycles, then ready: IRWrite only in the fourth
        MemReady = 1'b0;
        #1;
        chk("stall_irw_c1", 64'(IRWrite), 64'd0);
        step(OP_RTYPE, 1'b0); chk_state("stall_c2", 1);
        step(OP_RTYPE, 1'b0); chk_state("stall_c3", 1);
        chk("stall_irw_c3", 64'(IRWrite), 64'd0);
        step(OP_RTYPE, 1'b1); chk_state("stall_c4", 1);
        chk("stall_irw_c4", 64'(IRWrite), 64'd1);
        chk("stall_pcw_c4", 64'(PCWrite), 64'd1);
        step(OP_RTYPE, 1'b1); chk_state("stall_decode", 2);
        repeat (3) step(OP_RTYPE, 1'b1);
        chk_state("stall_done", 1);
        chk("stall_no_trap", 64'(Trap), 64'd0);

        // Fifteen stalls then ready on the limit cycle: completes normally
        MemReady = 1'b0;
        #1;
        repeat (14) step(OP_RTYPE, 1'b0);
        step(OP_RTYPE, 1'b1); chk_state("limit_ready_fetch", 1);
        step(OP_RTYPE, 1'b1); chk_state("limit_ready_decode", 2);
        chk("limit_ready_no_trap", 64'(Trap), 64'd0);
        repeat (3) step(OP_RTYPE, 1'b1);

        // Sixteen stalls: timeout trap, sticky until reset
        MemReady = 1'b0;
        #1;
        repeat (15) step(OP_RTYPE, 1'b0);
        chk_state("timeout_pre", 1);
        step(OP_RTYPE, 1'b0);
        chk_state("timeout_trap", 13);
        chk("timeout_trap_flag", 64'(Trap), 64'd1);
        chk("timeout_cause", 64'(TrapCause), 64'd2);
        repeat (3) step(OP_RTYPE, 1'b1);
        chk_state("timeout_sticky", 13);
        chk("timeout_ctrl", 64'(dut_ctrl), 64'd1);
        do_reset();
        chk("timeout_cause_cleared", 64'(TrapCause), 64'd0);

        // Illegal opcode
        step(6'b111111, 1'b1);
        step(6'b111111, 1'b1); chk_state("illegal_decode", 2);
        step(6'b111111, 1'b1); chk_state("illegal_trap", 13);
        chk("illegal_cause", 64'(TrapCause), 64'd1);
        do_reset();

        // Asynchronous reset while stalled in MEMRD
        step(OP_RTYPE, 1'b1);
        run_instr(OP_RTYPE, 4, "rtype2", lc, mw);
        step(OP_LW, 1'b1);
        step(OP_LW, 1'b1);
        step(OP_LW, 1'b0); chk_state("memrd_reached", 4);
        #1;
        rst = 1'b1;
        #1;
        chk_state("async_rst_state", 0);
        chk("async_rst_count", 64'(InstrCount), 64'd0);
        chk("async_rst_ctrl", 64'(dut_ctrl), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized run; opcode changes only while fetching so it is stable through execution
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (State == 4'd13) trap_cycles++;
            else trap_cycles = 0;
            rst = (trap_cycles == 3) || ($urandom_range(0, 399) == 0);
            if (State == 4'd1 && burst == 0 && $urandom_range(0, 49) == 0) begin
                burst = 14 + int'($urandom_range(0, 4));
            end
            if (State == 4'd1 || State == 4'd0) begin
                r = int'($urandom_range(0, 20));
                if (r < 20) Opcode = legal[r % 6];
                else Opcode = 6'($urandom_range(0, 63));
            end
            if (burst > 0) begin
                MemReady = 1'b0;
                burst--;
            end else begin
                MemReady = ($urandom_range(0, 99) < 75);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
